mem_arbiter: RTL and testbench

Single-owner arbiter for the processor's memory bus. It shares one combinational-read memory port between the 6502 core (`proc`, via a new RDY stall input) and a DMA/debug-loader requester. The core owns the bus by default. DMA steals cycles only on core read cycles, matching 6502 RDY semantics, and an optional fairness limit bounds DMA bursts. The block sits between `proc`, the DMA engine and the system RAM.

---
 rtl/proc_pkg.sv | 18 +
 rtl/arb_fair_counter.sv | 61 ++++++
 rtl/mem_arbiter.sv | 116 +++++++++++
 tb/tb_mem_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared processor-side definitions: bus widths, arbiter ownership states and reset vector.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package proc_pkg;

    localparam int PROC_ADDR_W = 16;
    localparam int PROC_DATA_W = 8;

    // 6502 reset vector locations read by the core after reset.
    localparam logic [15:0] RESET_VECTOR_LO = 16'hFFFC;
    localparam logic [15:0] RESET_VECTOR_HI = 16'hFFFD;

    typedef enum logic {
        CPU_OWN = 1'b0,
        DMA_OWN = 1'b1
    } arb_state_t;

endpackage

// File: rtl/arb_fair_counter.sv
// DMA burst limiter: counts beats, cuts over-long bursts, then reserves core cycles.
// Latency: limit_hit/grant_ok are combinational from registered counters; dma_preempt is registered (1 cycle).
// Backpressure: none of its own; it only gates the arbiter's grant and hand-back decisions.
//
// Ports: clk, reset (sync, active-high); dma_own (arbiter in DMA_OWN); beat (beat completes this edge);
//        last (current beat is final); limit_hit (this beat reaches MAX_BURST); grant_ok (cooldown expired);
//        dma_preempt (registered pulse after a forced hand-back).
module arb_fair_counter #(
    parameter int MAX_BURST      = 16,
    parameter int CPU_MIN_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic dma_own,
    input  logic beat,
    input  logic last,
    output logic limit_hit,
    output logic grant_ok,
    output logic dma_preempt
);

    localparam int BW = $clog2(MAX_BURST);
    localparam int CW = $clog2(CPU_MIN_CYCLES + 1);
    localparam logic [BW-1:0] BEAT_LAST = BW'(MAX_BURST - 1);
    localparam logic [CW-1:0] CD_LOAD   = CW'(CPU_MIN_CYCLES);
    localparam logic [CW-1:0] CD_ONE    = CW'(1);

    logic [BW-1:0] beat_cnt;
    logic [CW-1:0] cooldown;
    logic          forced;

    assign limit_hit = beat & (beat_cnt == BEAT_LAST);
    // A burst whose final beat happens to land on the limit ends normally, not by preemption.
    assign forced    = limit_hit & ~last;
    // The grant takes effect one edge after it is decided, so the last cooldown cycle may already
    // decide it: the core then gets exactly CPU_MIN_CYCLES cycles before DMA regains the bus.
    assign grant_ok  = (cooldown <= CD_ONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            beat_cnt    <= '0;
            cooldown    <= '0;
            dma_preempt <= 1'b0;
        end else begin
            if (!dma_own) begin
                beat_cnt <= '0;
            end else if (beat && (beat_cnt != BEAT_LAST)) begin
                beat_cnt <= beat_cnt + 1'b1;
            end

            if (forced) begin
                cooldown <= CD_LOAD;
            end else if (!dma_own && (cooldown != '0)) begin
                cooldown <= cooldown - 1'b1;
            end

            dma_preempt <= forced;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-owner arbiter sharing one combinational-read memory port between the 6502 core and a DMA requester.
// Latency: grant 1 cycle after a DMA request on a core read cycle; hand-back with no dead cycle.
// Backpressure: core stalled via cpu_rdy=0 while DMA owns the bus; DMA waits on dma_gnt; core writes never stolen.
//
// Ports: clk, reset (sync, active-high); cpu_* core bus and cpu_rdy stall; dma_* requester bus with dma_gnt grant
//        and dma_preempt pulse; mem_* shared memory port (read data valid in the same cycle as the address).
// Build option: define MEM_ARB_FAIR_EN to enable the MAX_BURST / CPU_MIN_CYCLES fairness limit.
module mem_arbiter
    import proc_pkg::*;
#(
    parameter int ADDR_W         = PROC_ADDR_W,
    parameter int DATA_W         = PROC_DATA_W,
    parameter int MAX_BURST      = 16,
    parameter int CPU_MIN_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic [DATA_W-1:0] cpu_wr_data,
    input  logic              cpu_wr_enable,
    output logic [DATA_W-1:0] cpu_rd_data,
    output logic              cpu_rdy,
    input  logic              dma_req,
    input  logic [ADDR_W-1:0] dma_address,
    input  logic [DATA_W-1:0] dma_wr_data,
    input  logic              dma_wr_enable,
    input  logic              dma_last,
    output logic              dma_gnt,
    output logic [DATA_W-1:0] dma_rd_data,
    output logic              dma_preempt,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_wr_data,
    output logic              mem_wr_enable,
    input  logic [DATA_W-1:0] mem_rd_data
);

    if (MAX_BURST < 2 || CPU_MIN_CYCLES < 1) begin : g_bad_cfg
        $error("mem_arbiter: MAX_BURST must be >= 2 and CPU_MIN_CYCLES >= 1");
    end

    arb_state_t state_q, state_d;
    logic       dma_own;
    logic       limit_hit;
    logic       grant_ok;

    assign dma_own = (state_q == DMA_OWN);

`ifdef MEM_ARB_FAIR_EN
    arb_fair_counter #(
        .MAX_BURST      (MAX_BURST),
        .CPU_MIN_CYCLES (CPU_MIN_CYCLES)
    ) u_fair (
        .clk         (clk),
        .reset       (reset),
        .dma_own     (dma_own),
        .beat        (dma_own & dma_req),
        .last        (dma_last),
        .limit_hit   (limit_hit),
        .grant_ok    (grant_ok),
        .dma_preempt (dma_preempt)
    );
`else
    assign limit_hit   = 1'b0;
    assign grant_ok    = 1'b1;
    assign dma_preempt = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= CPU_OWN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cpu_rdy       = 1'b0;
        dma_gnt       = 1'b0;
        mem_address   = cpu_address;
        mem_wr_data   = cpu_wr_data;
        mem_wr_enable = 1'b0;

        case (state_q)
            CPU_OWN: begin
                cpu_rdy       = 1'b1;
                mem_wr_enable = cpu_wr_enable;
                // Steal only core read cycles; the current read still completes this edge.
                if (dma_req && !cpu_wr_enable && grant_ok) begin
                    state_d = DMA_OWN;
                end
            end
            DMA_OWN: begin
                dma_gnt       = 1'b1;
                mem_address   = dma_address;
                mem_wr_data   = dma_wr_data;
                mem_wr_enable = dma_wr_enable & dma_req;
                // An idle cycle releases the bus; the in-flight beat always completes first.
                if (!dma_req || dma_last || limit_hit) begin
                    state_d = CPU_OWN;
                end
            end
        endcase

        // Reset abandons any burst at once: nobody owns the bus and nothing is written.
        if (reset) begin
            cpu_rdy       = 1'b0;
            dma_gnt       = 1'b0;
            mem_wr_enable = 1'b0;
        end
    end

    assign cpu_rd_data = mem_rd_data;
    assign dma_rd_data = mem_rd_data;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a 64 KiB combinational-read memory model.
// Latency: n/a.
// Backpressure: n/a.
module tb_mem_arbiter;
    import proc_pkg::*;

    localparam int AW = 16;
    localparam int DW = 8;

`ifdef MEM_ARB_FAIR_EN
    localparam logic [31:0] EXP_GNT_TR = 32'h0000_3CF3;  // C DDDD CC DDDD CC DD
    localparam logic [31:0] EXP_PRE_TR = 32'h0000_0208;  // pulses in the first core cycle after each cut
    localparam int          EXP_CYC    = 15;
`else
    localparam logic [31:0] EXP_GNT_TR = 32'h0000_03FF;  // C then 10 contiguous beats
    localparam logic [31:0] EXP_PRE_TR = 32'h0000_0000;
    localparam int          EXP_CYC    = 11;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] cpu_address;
    logic [DW-1:0] cpu_wr_data;
    logic          cpu_wr_enable;
    logic [DW-1:0] cpu_rd_data;
    logic          cpu_rdy;
    logic          dma_req;
    logic [AW-1:0] dma_address;
    logic [DW-1:0] dma_wr_data;
    logic          dma_wr_enable;
    logic          dma_last;
    logic          dma_gnt;
    logic [DW-1:0] dma_rd_data;
    logic          dma_preempt;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_wr_data;
    logic          mem_wr_enable;
    logic [DW-1:0] mem_rd_data;

    logic [DW-1:0] mem [0:65535];
    int            wr_count = 0;
    int            checks   = 0;
    int            failures = 0;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .MAX_BURST      (4),
        .CPU_MIN_CYCLES (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cpu_address   (cpu_address),
        .cpu_wr_data   (cpu_wr_data),
        .cpu_wr_enable (cpu_wr_enable),
        .cpu_rd_data   (cpu_rd_data),
        .cpu_rdy       (cpu_rdy),
        .dma_req       (dma_req),
        .dma_address   (dma_address),
        .dma_wr_data   (dma_wr_data),
        .dma_wr_enable (dma_wr_enable),
        .dma_last      (dma_last),
        .dma_gnt       (dma_gnt),
        .dma_rd_data   (dma_rd_data),
        .dma_preempt   (dma_preempt),
        .mem_address   (mem_address),
        .mem_wr_data   (mem_wr_data),
        .mem_wr_enable (mem_wr_enable),
        .mem_rd_data   (mem_rd_data)
    );

    // Memory model: combinational read, write on the rising edge.
    assign mem_rd_data = mem[mem_address];

    always @(posedge clk) begin
        if (mem_wr_enable) begin
            mem[mem_address] <= mem_wr_data;
            wr_count         <= wr_count + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int            base;
        int            stall;
        int            beat;
        int            cyc;
        logic [31:0]   gnt_tr;
        logic [31:0]   pre_tr;

        for (int a = 0; a < 65536; a++) mem[a] = '0;
        mem[RESET_VECTOR_LO] = 8'h34;
        mem[RESET_VECTOR_HI] = 8'h12;

        // Reset held with a pending DMA write and a core write.
        reset         = 1'b1;
        cpu_address   = 16'h0010;
        cpu_wr_data   = 8'hEE;
        cpu_wr_enable = 1'b1;
        dma_req       = 1'b1;
        dma_address   = 16'h0020;
        dma_wr_data   = 8'hDD;
        dma_wr_enable = 1'b1;
        dma_last      = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk("rst_mem_we", mem_wr_enable, 0);
            chk("rst_gnt", dma_gnt, 0);
            chk("rst_rdy", cpu_rdy, 0);
        end
        reset         = 1'b0;
        dma_req       = 1'b0;
        cpu_wr_enable = 1'b0;
        dma_wr_enable = 1'b0;
        #1;
        chk("rst_exit_rdy", cpu_rdy, 1);
        chk("rst_exit_gnt", dma_gnt, 0);
        chk("rst_exit_preempt", dma_preempt, 0);
        chk("rst_no_write", wr_count, 0);

        // Core write while DMA request rises: no steal until the next core read.
        @(negedge clk);
        cpu_address   = 16'h0200;
        cpu_wr_data   = 8'hA5;
        cpu_wr_enable = 1'b1;
        dma_req       = 1'b1;
        dma_address   = 16'h0200;
        dma_wr_enable = 1'b0;
        dma_last      = 1'b1;
        #1;
        chk("wp_mem_we", mem_wr_enable, 1);
        chk("wp_mem_addr", mem_address, 16'h0200);
        chk("wp_rdy", cpu_rdy, 1);
        @(negedge clk);
        cpu_wr_enable = 1'b0;
        #1;
        chk("wp_no_steal", dma_gnt, 0);
        chk("wp_cpu_rd", cpu_rd_data, 8'hA5);
        @(negedge clk); #1;
        chk("wp_gnt_after_read", dma_gnt, 1);
        chk("wp_rdy_stall", cpu_rdy, 0);
        chk("wp_dma_rd", dma_rd_data, 8'hA5);
        @(negedge clk);
        dma_req  = 1'b0;
        dma_last = 1'b0;
        #1;
        chk("wp_handback", cpu_rdy, 1);

        // Short 3-beat write burst ending on dma_last.
        @(negedge clk);
        dma_req       = 1'b1;
        dma_wr_enable = 1'b1;
        dma_address   = 16'h0300;
        dma_wr_data   = 8'h11;
        #1;
        chk("sb_arb_rdy", cpu_rdy, 1);
        base  = wr_count;
        stall = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            dma_address = 16'h0300 + 16'(i);
            dma_wr_data = 8'(8'h11 * (i + 1));
            dma_last    = (i == 2);
            #1;
            if (!cpu_rdy) stall++;
            chk("sb_gnt", dma_gnt, 1);
            chk("sb_mem_addr", mem_address, 16'h0300 + 16'(i));
        end
        @(negedge clk);
        dma_req       = 1'b0;
        dma_last      = 1'b0;
        dma_wr_enable = 1'b0;
        #1;
        chk("sb_handback", cpu_rdy, 1);
        chk("sb_stall_cycles", stall, 3);
        chk("sb_write_count", wr_count - base, 3);
        chk("sb_mem_0300", mem[16'h0300], 8'h11);
        chk("sb_mem_0302", mem[16'h0302], 8'h33);

        // Idle release after one beat without dma_last.
        @(negedge clk);
        dma_req       = 1'b1;
        dma_wr_enable = 1'b1;
        dma_address   = 16'h0400;
        dma_wr_data   = 8'h44;
        #1;
        @(negedge clk); #1;
        chk("idle_beat_gnt", dma_gnt, 1);
        base = wr_count;
        @(negedge clk);
        dma_req     = 1'b0;
        dma_address = 16'h0401;
        dma_wr_data = 8'h55;
        #1;
        chk("idle_still_gnt", dma_gnt, 1);
        chk("idle_no_write", mem_wr_enable, 0);
        @(negedge clk);
        dma_wr_enable = 1'b0;
        #1;
        chk("idle_cpu_own", cpu_rdy, 1);
        chk("idle_gnt_off", dma_gnt, 0);
        chk("idle_write_count", wr_count - base, 1);
        chk("idle_mem_0401", mem[16'h0401], 8'h00);

        // 10-beat request held continuously; core keeps reading.
        cpu_address = 16'h0200;
        beat   = 0;
        cyc    = 0;
        gnt_tr = '0;
        pre_tr = '0;
        base   = wr_count;
        while (beat < 10 && cyc < 40) begin
            @(negedge clk);
            dma_req       = 1'b1;
            dma_wr_enable = 1'b1;
            dma_address   = 16'h0500 + 16'(beat);
            dma_wr_data   = 8'(8'h80 + beat);
            dma_last      = (beat == 9);
            #1;
            gnt_tr = {gnt_tr[30:0], dma_gnt};
            pre_tr = {pre_tr[30:0], dma_preempt};
            if (dma_gnt) beat++;
            cyc++;
        end
        @(negedge clk);
        dma_req       = 1'b0;
        dma_last      = 1'b0;
        dma_wr_enable = 1'b0;
        #1;
        chk("burst_beats_done", beat, 10);
        chk("burst_cycles", cyc, EXP_CYC);
        chk("burst_gnt_trace", gnt_tr, EXP_GNT_TR);
        chk("burst_preempt_trace", pre_tr, EXP_PRE_TR);
        chk("burst_write_count", wr_count - base, 10);
        chk("burst_mem_0509", mem[16'h0509], 8'h89);
        chk("burst_handback", cpu_rdy, 1);
        chk("burst_no_preempt_on_last", dma_preempt, 0);

        // DMA reads of the reset vector.
        @(negedge clk);
        dma_req     = 1'b1;
        dma_address = RESET_VECTOR_LO;
        #1;
        @(negedge clk); #1;
        chk("vec_gnt", dma_gnt, 1);
        chk("vec_lo", dma_rd_data, 8'h34);
        chk("vec_no_write", mem_wr_enable, 0);
        @(negedge clk);
        dma_address = RESET_VECTOR_HI;
        dma_last    = 1'b1;
        #1;
        chk("vec_hi", dma_rd_data, 8'h12);
        chk("vec_hi_fanout", cpu_rd_data, 8'h12);
        @(negedge clk);
        dma_req  = 1'b0;
        dma_last = 1'b0;
        #1;
        chk("vec_handback", cpu_rdy, 1);

        // Reset in the middle of a write burst.
        @(negedge clk);
        dma_req       = 1'b1;
        dma_wr_enable = 1'b1;
        dma_address   = 16'h0600;
        dma_wr_data   = 8'h66;
        #1;
        @(negedge clk); #1;
        chk("mid_rst_gnt", dma_gnt, 1);
        base = wr_count;
        @(negedge clk);
        reset       = 1'b1;
        dma_address = 16'h0601;
        dma_wr_data = 8'h77;
        #1;
        chk("mid_rst_mem_we", mem_wr_enable, 0);
        chk("mid_rst_gnt_off", dma_gnt, 0);
        chk("mid_rst_rdy_off", cpu_rdy, 0);
        @(negedge clk);
        reset         = 1'b0;
        dma_req       = 1'b0;
        dma_wr_enable = 1'b0;
        #1;
        chk("mid_rst_cpu_own", cpu_rdy, 1);
        chk("mid_rst_write_count", wr_count - base, 1);
        chk("mid_rst_mem_0601", mem[16'h0601], 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
